hex_display_scan: RTL and testbench

- Time-multiplexed scanner for an N-digit common-anode 7-segment display.
- Sits directly upstream of the hex-to-7-segment decoder. Each scan slot drives one 4-bit nibble into the decoder's 4-bit input (SW) and asserts one active-low anode enable.
- Captures the full digit vector once per frame so a frame never mixes two values, and optionally blanks leading zeros.

---
 rtl/hex_display_scan.sv | 111 +++++++++++
 tb/tb_hex_display_scan.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// Time-multiplexed scanner for an N-digit common-anode 7-segment display.
// Captures the digit vector once per frame and optionally blanks leading zeros.
module hex_display_scan #(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    blank_lz,
  input  logic [4*N_DIGITS-1:0]   digits_i,
  input  logic [N_DIGITS-1:0]     dp_i,
  output logic [3:0]              digit_o,
  output logic [N_DIGITS-1:0]     an_o,
  output logic                    dp_o,
  output logic                    frame_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(N_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           r_oidx;
  logic [4*N_DIGITS-1:0]   r_shadow;
  logic [N_DIGITS-1:0]     r_shadow_dp;
  logic                    r_primed;
  logic                    r_shown;
  logic [3:0]              r_digit;
  logic [N_DIGITS-1:0]     r_an;
  logic                    r_dp;
  logic                    r_frame;

  logic                    w_tick;
  logic                    w_load;
  logic [3:0]              w_nib;
  logic                    w_sdp;
  logic [N_DIGITS-1:0]     w_an;
  logic                    w_blank;
  logic                    w_allz;

  assign w_tick = en && (r_cnt == CMAX);
  assign w_load = (en && !r_primed) || (w_tick && (r_idx == IMAX));

  // Walk from the top digit down so w_allz covers every nibble >= k.
  always_comb begin
    w_nib   = 4'h0;
    w_sdp   = 1'b0;
    w_an    = '1;
    w_blank = 1'b0;
    w_allz  = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_allz = w_allz && (r_shadow[4*k +: 4] == 4'h0);
      if (r_idx == IW'(k)) begin
        w_nib   = r_shadow[4*k +: 4];
        w_sdp   = r_shadow_dp[k];
        w_an[k] = 1'b0;
        w_blank = blank_lz && (k != 0) && w_allz;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_oidx      <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_primed    <= 1'b0;
      r_shown     <= 1'b0;
      r_digit     <= 4'h0;
      r_an        <= '1;
      r_dp        <= 1'b1;
      r_frame     <= 1'b0;
    end else if (en) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == IMAX) ? '0 : r_idx + 1'b1;
      end
      if (w_load) begin
        r_shadow    <= digits_i;
        r_shadow_dp <= dp_i;
        r_primed    <= 1'b1;
      end
      if (r_primed) begin
        if (w_blank) begin
          r_digit <= 4'h0;
          r_an    <= '1;
          r_dp    <= 1'b1;
        end else begin
          r_digit <= w_nib;
          r_an    <= w_an;
          r_dp    <= ~w_sdp;
        end
        r_shown <= 1'b1;
        r_oidx  <= r_idx;
        // Pulse only on the first cycle slot 0 reaches the outputs.
        r_frame <= (r_idx == '0) && (!r_shown || (r_oidx != '0));
      end
    end
  end

  assign digit_o = r_digit;
  assign an_o    = r_an;
  assign dp_o    = r_dp;
  assign frame_o = r_frame && en;

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench for hex_display_scan: randomized and directed stimulus
// against a cycle-level reference model of the scan behaviour.
module tb_hex_display_scan;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           blank_lz;
  logic [4*N-1:0] digits_i;
  logic [N-1:0]   dp_i;
  logic [3:0]     digit_o;
  logic [N-1:0]   an_o;
  logic           dp_o;
  logic           frame_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]   dig;
    logic [N-1:0] an;
    logic         dp;
    logic         fr;
  } exp_t;

  exp_t q[$];

  hex_display_scan #(.N_DIGITS(N), .DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .blank_lz (blank_lz),
    .digits_i (digits_i),
    .dp_i     (dp_i),
    .digit_o  (digit_o),
    .an_o     (an_o),
    .dp_o     (dp_o),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  // Reference model state, kept as plain integers.
  int         m_cnt, m_slot, m_last_slot;
  int         m_shadow;
  logic [N-1:0] m_sdp;
  bit         m_primed, m_shown;
  exp_t       m_out;

  initial begin
    m_cnt = 0; m_slot = 0; m_last_slot = 0;
    m_shadow = 0; m_sdp = '0;
    m_primed = 0; m_shown = 0;
    m_out = '{dig: 4'h0, an: '1, dp: 1'b1, fr: 1'b0};
  end

  always @(posedge clk) begin
    bit tick;
    bit load;
    if (!rst_n) begin
      m_cnt = 0; m_slot = 0; m_last_slot = 0;
      m_shadow = 0; m_sdp = '0;
      m_primed = 0; m_shown = 0;
      m_out = '{dig: 4'h0, an: '1, dp: 1'b1, fr: 1'b0};
    end else if (en) begin
      tick = (m_cnt == DIV - 1);
      load = !m_primed || (tick && m_slot == N - 1);
      if (m_primed) begin
        if (blank_lz && m_slot != 0 && (m_shadow >> (4 * m_slot)) == 0) begin
          m_out.dig = 4'h0;
          m_out.an  = '1;
          m_out.dp  = 1'b1;
        end else begin
          m_out.dig = 4'((m_shadow >> (4 * m_slot)) & 15);
          m_out.an  = N'(~(1 << m_slot));
          m_out.dp  = ~m_sdp[m_slot];
        end
        m_out.fr = (m_slot == 0) && (!m_shown || m_last_slot != 0);
        m_shown = 1;
        m_last_slot = m_slot;
      end
      m_cnt = (m_cnt + 1) % DIV;
      if (tick) m_slot = (m_slot + 1) % N;
      if (load) begin
        m_shadow = int'(digits_i);
        m_sdp = dp_i;
        m_primed = 1;
      end
    end
    q.push_back(m_out);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      e.fr = e.fr && en;
      checks++;
      if ({digit_o, an_o, dp_o, frame_o} !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got dig=%h an=%b dp=%b fr=%b want dig=%h an=%b dp=%b fr=%b",
                 $time, digit_o, an_o, dp_o, frame_o, e.dig, e.an, e.dp, e.fr);
      end
      checks++;
      if ($countones(~an_o) > 1) begin
        failures++;
        $display("FAIL onehot t=%0t got an=%b want at most one low", $time, an_o);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; blank_lz = 1'b0;
    digits_i = 16'h1234; dp_i = '0;
    step(3);
    rst_n = 1'b1; en = 1'b1;
    step(37);
    digits_i = 16'hABCD;
    step(40);
    digits_i = 16'h0050; blank_lz = 1'b1;
    step(40);
    digits_i = 16'h0000;
    step(40);
    digits_i = 16'h9876; blank_lz = 1'b0; dp_i = 4'b0100;
    step(42);
    en = 1'b0;
    step(10);
    en = 1'b1;
    step(30);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(40);
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) begin
        digits_i = 16'($urandom);
        if ($urandom_range(0, 2) == 0) digits_i &= 16'h00FF;
        if ($urandom_range(0, 4) == 0) digits_i = 16'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 29) == 0) dp_i = N'($urandom);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      rst_n = ($urandom_range(0, 399) != 0);
      step(1);
    end
    rst_n = 1'b1;
    step(3);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
